count_bcd_display: RTL and testbench

COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

---
 rtl/count_bcd_display_if.sv | 31 +++
 rtl/count_bcd_display.sv | 144 ++++++++++++++
 tb/tb_count_bcd_display.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/count_bcd_display_if.sv
// Bundles the converter request and result/display signals.
// The master side drives count_in and load; the slave (converter) drives everything else.
interface count_bcd_display_if;
  logic [7:0]  count_in;
  logic        load;
  logic        busy;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  digit_sel;

  modport master (
    output count_in,
    output load,
    input  busy,
    input  bcd_out,
    input  bcd_valid,
    input  seg,
    input  digit_sel
  );

  modport slave (
    input  count_in,
    input  load,
    output busy,
    output bcd_out,
    output bcd_valid,
    output seg,
    output digit_sel
  );
endinterface

// File: rtl/count_bcd_display.sv
// Sequential double-dabble converter (8-bit binary to 3-digit BCD) driving a
// multiplexed 7-segment scan with leading-zero blanking.
module count_bcd_display #(
  parameter int REFRESH_DIV = 1024
) (
  input logic              clk,
  input logic              rst,
  count_bcd_display_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [15:0] DIV_MAX = 16'(REFRESH_DIV - 1);

  logic [1:0]  state_q,     state_d;
  logic [7:0]  bin_q,       bin_d;
  logic [11:0] bcd_q,       bcd_d;
  logic [2:0]  cnt_q,       cnt_d;
  logic [11:0] bcd_out_q,   bcd_out_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q,      busy_d;
  logic [15:0] div_q,       div_d;
  logic [2:0]  digit_sel_q, digit_sel_d;

  logic [11:0] bcd_adj;
  logic [3:0]  digit_nib;
  logic        digit_blank;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Result, valid and busy are registered off the FSM state, so they trail it by one edge.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = (state_q == S_DONE);
    busy_d      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          bin_d   = bus.count_in;
          bcd_d   = 12'h000;
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[10:0], bin_q[7]};
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_out_d = bcd_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d       = (div_q == DIV_MAX) ? 16'd0 : div_q + 16'd1;
    digit_sel_d = (div_q == DIV_MAX) ? {digit_sel_q[1:0], digit_sel_q[2]} : digit_sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= 8'h00;
      bcd_q       <= 12'h000;
      cnt_q       <= 3'd0;
      bcd_out_q   <= 12'h000;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      div_q       <= 16'd0;
      digit_sel_q <= 3'b001;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      div_q       <= div_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_enc = 7'h7E;
      4'd1:    seg_enc = 7'h30;
      4'd2:    seg_enc = 7'h6D;
      4'd3:    seg_enc = 7'h79;
      4'd4:    seg_enc = 7'h33;
      4'd5:    seg_enc = 7'h5B;
      4'd6:    seg_enc = 7'h5F;
      4'd7:    seg_enc = 7'h70;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h7B;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  // Tens is blanked only when hundreds is also zero, so 100 still shows its middle 0.
  always_comb begin
    digit_nib   = bcd_out_q[3:0];
    digit_blank = 1'b0;
    case (digit_sel_q)
      3'b010: begin
        digit_nib   = bcd_out_q[7:4];
        digit_blank = (bcd_out_q[11:8] == 4'd0) && (bcd_out_q[7:4] == 4'd0);
      end
      3'b100: begin
        digit_nib   = bcd_out_q[11:8];
        digit_blank = (bcd_out_q[11:8] == 4'd0);
      end
      default: begin
        digit_nib   = bcd_out_q[3:0];
        digit_blank = 1'b0;
      end
    endcase
  end

  assign bus.seg       = digit_blank ? 7'h00 : seg_enc(digit_nib);
  assign bus.digit_sel = digit_sel_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: conversion timing, results, blanking,
// load masking, reset abort and the digit scan.
module tb_count_bcd_display;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  count_bcd_display_if bus();

  count_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents v with load for exactly one edge (edge N); returns just after edge N.
  task automatic start_load(input logic [7:0] v);
    bus.count_in = v;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Watches one full scan period and records the segments shown for each digit.
  task automatic capture_scan(output logic [6:0] s1, output logic [6:0] s10, output logic [6:0] s100);
    s1   = 'x;
    s10  = 'x;
    s100 = 'x;
    for (int i = 0; i < 12; i++) begin
      case (bus.digit_sel)
        3'b001:  s1   = bus.seg;
        3'b010:  s10  = bus.seg;
        3'b100:  s100 = bus.seg;
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.bcd_valid); end
    checks++; if (bus.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h want=000", bus.bcd_out); end
    checks++; if (bus.digit_sel !== 3'b001) begin errors++; $display("FAIL reset_digit_sel got=%b want=001", bus.digit_sel); end
    checks++; if (bus.seg !== 7'h7E) begin errors++; $display("FAIL reset_seg got=%h want=7E", bus.seg); end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [6:0] s1, s10, s100;
    start_load(8'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({bus.busy, bus.bcd_valid} !== 2'b10) begin
        errors++; $display("FAIL zero_shift edge=N+%0d busy,valid got=%b want=10", k, {bus.busy, bus.bcd_valid});
      end
    end
    tick();
    checks++; if ({bus.busy, bus.bcd_valid} !== 2'b11) begin errors++; $display("FAIL zero_done busy,valid got=%b want=11", {bus.busy, bus.bcd_valid}); end
    checks++; if (bus.bcd_out !== 12'h000) begin errors++; $display("FAIL zero_bcd got=%h want=000", bus.bcd_out); end
    tick();
    checks++; if ({bus.busy, bus.bcd_valid} !== 2'b00) begin errors++; $display("FAIL zero_idle busy,valid got=%b want=00", {bus.busy, bus.bcd_valid}); end
    capture_scan(s1, s10, s100);
    checks++; if ({s100, s10, s1} !== {7'h00, 7'h00, 7'h7E}) begin errors++; $display("FAIL zero_scan h,t,o got=%h,%h,%h want=00,00,7E", s100, s10, s1); end
    $display("transaction: load 0 -> bcd %h", bus.bcd_out);
  endtask

  task automatic test_max();
    logic [6:0] s1, s10, s100;
    start_load(8'd255);
    repeat (8) tick();
    checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid got=%b want=0", bus.bcd_valid); end
    tick();
    checks++; if (bus.bcd_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%b want=1", bus.bcd_valid); end
    checks++; if (bus.bcd_out !== 12'h255) begin errors++; $display("FAIL max_bcd got=%h want=255", bus.bcd_out); end
    capture_scan(s1, s10, s100);
    checks++; if ({s100, s10, s1} !== {7'h6D, 7'h5B, 7'h5B}) begin errors++; $display("FAIL max_scan h,t,o got=%h,%h,%h want=6D,5B,5B", s100, s10, s1); end
    $display("transaction: load 255 -> bcd %h", bus.bcd_out);
  endtask

  task automatic test_hundred();
    logic [6:0] s1, s10, s100;
    start_load(8'd100);
    repeat (9) tick();
    checks++; if (bus.bcd_out !== 12'h100) begin errors++; $display("FAIL hundred_bcd got=%h want=100", bus.bcd_out); end
    capture_scan(s1, s10, s100);
    checks++; if ({s100, s10, s1} !== {7'h30, 7'h7E, 7'h7E}) begin errors++; $display("FAIL hundred_scan h,t,o got=%h,%h,%h want=30,7E,7E", s100, s10, s1); end
    $display("transaction: load 100 -> bcd %h", bus.bcd_out);
    start_load(8'd7);
    repeat (9) tick();
    checks++; if (bus.bcd_out !== 12'h007) begin errors++; $display("FAIL seven_bcd got=%h want=007", bus.bcd_out); end
    capture_scan(s1, s10, s100);
    checks++; if ({s100, s10, s1} !== {7'h00, 7'h00, 7'h70}) begin errors++; $display("FAIL seven_scan h,t,o got=%h,%h,%h want=00,00,70", s100, s10, s1); end
    $display("transaction: load 7 -> bcd %h", bus.bcd_out);
  endtask

  task automatic test_back_to_back();
    start_load(8'd42);
    bus.count_in = 8'd99;
    for (int k = 1; k <= 10; k++) begin
      bus.load = (k == 3 || k == 9 || k == 10);
      tick();
      if (k <= 9) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy edge=N+%0d got=%b want=1", k, bus.busy); end
      end
      if (k <= 8) begin
        checks++; if (bus.bcd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid edge=N+%0d got=%b want=0", k, bus.bcd_valid); end
      end
      if (k == 9) begin
        checks++; if (bus.bcd_valid !== 1'b1) begin errors++; $display("FAIL b2b_done_valid got=%b want=1", bus.bcd_valid); end
        checks++; if (bus.bcd_out !== 12'h042) begin errors++; $display("FAIL b2b_first_bcd got=%h want=042", bus.bcd_out); end
      end
      if (k == 10) begin
        checks++; if ({bus.busy, bus.bcd_valid} !== 2'b00) begin errors++; $display("FAIL b2b_gap busy,valid got=%b want=00", {bus.busy, bus.bcd_valid}); end
      end
    end
    bus.load = 1'b0;
    $display("transaction: load 42 (99 presented mid-conversion) -> bcd %h", bus.bcd_out);
    repeat (8) tick();
    checks++; if ({bus.busy, bus.bcd_valid, bus.bcd_out} !== {2'b10, 12'h042}) begin
      errors++; $display("FAIL b2b_hold busy,valid,bcd got=%b,%b,%h want=1,0,042", bus.busy, bus.bcd_valid, bus.bcd_out);
    end
    tick();
    checks++; if ({bus.bcd_valid, bus.bcd_out} !== {1'b1, 12'h099}) begin
      errors++; $display("FAIL b2b_second valid,bcd got=%b,%h want=1,099", bus.bcd_valid, bus.bcd_out);
    end
    $display("transaction: load 99 at N+10 -> bcd %h", bus.bcd_out);
    tick();
  endtask

  task automatic test_abort();
    int pulses;
    int busy_seen;
    start_load(8'd200);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.busy, bus.bcd_valid, bus.bcd_out} !== {2'b00, 12'h000}) begin
      errors++; $display("FAIL abort_state busy,valid,bcd got=%b,%b,%h want=0,0,000", bus.busy, bus.bcd_valid, bus.bcd_out);
    end
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.bcd_valid === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_valid pulses got=%0d want=0", pulses); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL abort_no_busy cycles got=%0d want=0", busy_seen); end
    checks++; if (bus.bcd_out !== 12'h000) begin errors++; $display("FAIL abort_bcd got=%h want=000", bus.bcd_out); end
    $display("transaction: load 200 aborted by reset at N+4 -> bcd %h", bus.bcd_out);
    bus.count_in = 8'd55;
    rst = 1'b1;
    bus.load = 1'b1;
    tick();
    rst = 1'b0;
    bus.load = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_over_load busy got=%b want=0", bus.busy); end
    $display("transaction: reset with load 55 -> busy %b", bus.busy);
  endtask

  task automatic test_scan();
    logic [2:0] exp_sel;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.digit_sel !== 3'b001) begin errors++; $display("FAIL scan_start got=%b want=001", bus.digit_sel); end
    for (int k = 1; k <= 16; k++) begin
      bus.count_in = 8'd123;
      bus.load = (k == 5);
      tick();
      case ((k / 4) % 3)
        0:       exp_sel = 3'b001;
        1:       exp_sel = 3'b010;
        default: exp_sel = 3'b100;
      endcase
      checks++; if (bus.digit_sel !== exp_sel) begin
        errors++; $display("FAIL scan_sel edge=R+%0d got=%b want=%b", k, bus.digit_sel, exp_sel);
      end
    end
    bus.load = 1'b0;
    checks++; if (bus.bcd_out !== 12'h123) begin errors++; $display("FAIL scan_conv_bcd got=%h want=123", bus.bcd_out); end
    $display("transaction: scan with load 123 -> bcd %h", bus.bcd_out);
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.count_in = 8'd0;
    test_reset();
    test_zero();
    test_max();
    test_hundred();
    test_back_to_back();
    test_abort();
    test_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
